// File: rtl/ifetch_line_buffer_if.sv
// Bundle of fetch-side and memport-side signals for the single-line
// instruction fetch buffer. The slave modport is the buffer's view.
// The master modport is the surrounding fetch stage plus memport.
interface ifetch_line_buffer_if #(
    parameter int DATA_WIDTH = 256
);
    // fetch side
    logic [31:0]           ufp_addr;
    logic [3:0]            ufp_rmask;
    logic                  ufp_ready;
    logic [31:0]           ufp_rdata;
    logic                  ufp_resp;
    logic                  flush;

    // memport side
    logic [31:0]           mem_addr;
    logic                  mem_read;
    logic                  mem_resp;
    logic [DATA_WIDTH-1:0] mem_rdata;

    modport slave (
        input  ufp_addr,
        input  ufp_rmask,
        input  flush,
        input  mem_resp,
        input  mem_rdata,
        output ufp_ready,
        output ufp_rdata,
        output ufp_resp,
        output mem_addr,
        output mem_read
    );

    modport master (
        output ufp_addr,
        output ufp_rmask,
        output flush,
        output mem_resp,
        output mem_rdata,
        input  ufp_ready,
        input  ufp_rdata,
        input  ufp_resp,
        input  mem_addr,
        input  mem_read
    );
endinterface

// File: rtl/ifetch_line_buffer.sv
// Single-line instruction fetch buffer. Holds one 256-bit line plus tag,
// answers hits in one cycle and fills the line from memport on a miss.
//
// state     | meaning
// ----------+---------------------------------------------------------
// IDLE      | ready for a fetch; hits answered next cycle
// FILL      | line read outstanding, answer the fetch when it returns
// FLUSHWAIT | line read outstanding after a redirect; fill silently
module ifetch_line_buffer #(
    parameter int DATA_WIDTH = 256
) (
    input logic                  clk,
    input logic                  rst,
    ifetch_line_buffer_if.slave  bus
);
    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        FILL      = 2'd1,
        FLUSHWAIT = 2'd2
    } state_t;

    state_t            state_q, state_d;

    logic              valid_q;
    logic [26:0]       tag_q;
    logic [7:0][31:0]  line_q;
    logic [29:0]       req_addr_q, req_addr_d;

    logic              resp_q, resp_d;
    logic [31:0]       rdata_q, rdata_d;
    logic              mem_read_q, mem_read_d;
    logic [31:0]       mem_addr_q, mem_addr_d;
    logic              fill_en;

    logic              accept;
    logic              hit;
    logic [7:0][31:0]  mem_words;
    logic [1:0]        unused_byte_offset;

    // byte offset within a word never affects which word is returned
    assign unused_byte_offset = bus.ufp_addr[1:0];

    assign mem_words = bus.mem_rdata[255:0];

    // ready is the only combinational output; it must be low during reset
    assign bus.ufp_ready = (state_q == IDLE) && !rst;

    assign accept = bus.ufp_ready && (bus.ufp_rmask != 4'b0000) && !bus.flush;
    assign hit    = valid_q && (tag_q == bus.ufp_addr[31:5]);

    assign bus.ufp_resp  = resp_q;
    assign bus.ufp_rdata = rdata_q;
    assign bus.mem_read  = mem_read_q;
    assign bus.mem_addr  = mem_addr_q;

    // next-state and registered-output decode
    always_comb begin
        state_d    = state_q;
        resp_d     = 1'b0;
        rdata_d    = rdata_q;
        mem_read_d = mem_read_q;
        mem_addr_d = mem_addr_q;
        req_addr_d = req_addr_q;
        fill_en    = 1'b0;

        case (state_q)
            IDLE: begin
                // a stray mem_resp here is ignored on purpose
                if (accept) begin
                    req_addr_d = bus.ufp_addr[31:2];
                    if (hit) begin
                        resp_d  = 1'b1;
                        rdata_d = line_q[bus.ufp_addr[4:2]];
                    end else begin
                        state_d    = FILL;
                        mem_read_d = 1'b1;
                        mem_addr_d = {bus.ufp_addr[31:5], 5'b0_0000};
                    end
                end
            end
            FILL: begin
                if (bus.mem_resp) begin
                    fill_en    = 1'b1;
                    mem_read_d = 1'b0;
                    state_d    = IDLE;
                    // a redirect in the same cycle still keeps the line
                    if (!bus.flush) begin
                        resp_d  = 1'b1;
                        rdata_d = mem_words[req_addr_q[2:0]];
                    end
                end else if (bus.flush) begin
                    // memport cannot abort a line read; wait it out
                    state_d = FLUSHWAIT;
                end
            end
            FLUSHWAIT: begin
                if (bus.mem_resp) begin
                    fill_en    = 1'b1;
                    mem_read_d = 1'b0;
                    state_d    = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // FSM state and registered outputs
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            resp_q     <= 1'b0;
            rdata_q    <= 32'h0;
            mem_read_q <= 1'b0;
            mem_addr_q <= 32'h0;
            req_addr_q <= 30'h0;
        end else begin
            state_q    <= state_d;
            resp_q     <= resp_d;
            rdata_q    <= rdata_d;
            mem_read_q <= mem_read_d;
            mem_addr_q <= mem_addr_d;
            req_addr_q <= req_addr_d;
        end
    end

    // line storage; tag comes from the outstanding read address
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= 27'h0;
            line_q  <= '0;
        end else if (fill_en) begin
            valid_q <= 1'b1;
            tag_q   <= mem_addr_q[31:5];
            line_q  <= mem_words;
        end
    end
endmodule

// File: tb/tb_ifetch_line_buffer.sv
module tb_ifetch_line_buffer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    ifetch_line_buffer_if #(.DATA_WIDTH(256)) bus ();

    ifetch_line_buffer #(.DATA_WIDTH(256)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    function automatic logic [255:0] mk_line(input logic [31:0] seed);
        logic [255:0] l;
        for (int i = 0; i < 8; i++) l[i*32 +: 32] = seed + 32'(i);
        return l;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic fetch(input logic [31:0] a);
        bus.ufp_addr  = a;
        bus.ufp_rmask = 4'hF;
    endtask

    task automatic test_reset();
        tick();
        checks++;
        if (bus.ufp_ready !== 1'b0 || bus.ufp_resp !== 1'b0 || bus.mem_read !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: got ready=%b resp=%b mem_read=%b want 0 0 0", bus.ufp_ready, bus.ufp_resp, bus.mem_read);
        end
        checks++;
        if (bus.mem_addr !== 32'h0 || bus.ufp_rdata !== 32'h0) begin
            errors++;
            $display("FAIL reset_data: got mem_addr=%h rdata=%h want 0 0", bus.mem_addr, bus.ufp_rdata);
        end
        rst = 1'b0;
        #1;
        checks++;
        if (bus.ufp_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release_ready: got %b want 1", bus.ufp_ready);
        end
        tick();
    endtask

    task automatic test_cold_fetch();
        fetch(32'h6000_0004);
        tick();
        bus.ufp_rmask = 4'h0;
        for (int i = 1; i <= 9; i++) begin
            checks++;
            if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h6000_0000 || bus.ufp_ready !== 1'b0 || bus.ufp_resp !== 1'b0) begin
                errors++;
                $display("FAIL cold_hold c%0d: got mem_read=%b addr=%h ready=%b resp=%b want 1 60000000 0 0", i, bus.mem_read, bus.mem_addr, bus.ufp_ready, bus.ufp_resp);
            end
            tick();
        end
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = mk_line(32'h0000_0012);
        tick();
        bus.mem_resp  = 1'b0;
        checks++;
        if (bus.ufp_resp !== 1'b1 || bus.ufp_rdata !== 32'h0000_0013) begin
            errors++;
            $display("FAIL cold_resp: got resp=%b rdata=%h want 1 00000013", bus.ufp_resp, bus.ufp_rdata);
        end
        checks++;
        if (bus.mem_read !== 1'b0 || bus.ufp_ready !== 1'b1) begin
            errors++;
            $display("FAIL cold_after: got mem_read=%b ready=%b want 0 1", bus.mem_read, bus.ufp_ready);
        end
        tick();
        checks++;
        if (bus.ufp_resp !== 1'b0) begin
            errors++;
            $display("FAIL cold_single_pulse: got resp=%b want 0", bus.ufp_resp);
        end
    endtask

    task automatic test_hit_stream();
        logic [31:0] addrs [3];
        logic [31:0] words [3];
        addrs = '{32'h6000_0000, 32'h6000_0008, 32'h6000_001C};
        words = '{32'h0000_0012, 32'h0000_0014, 32'h0000_0019};
        for (int i = 0; i < 3; i++) begin
            fetch(addrs[i]);
            tick();
            checks++;
            if (bus.ufp_resp !== 1'b1 || bus.ufp_rdata !== words[i] || bus.mem_read !== 1'b0) begin
                errors++;
                $display("FAIL hit_stream%0d: got resp=%b rdata=%h mem_read=%b want 1 %h 0", i, bus.ufp_resp, bus.ufp_rdata, bus.mem_read, words[i]);
            end
        end
        bus.ufp_rmask = 4'h0;
        tick();
        checks++;
        if (bus.ufp_resp !== 1'b0) begin
            errors++;
            $display("FAIL hit_stream_end: got resp=%b want 0", bus.ufp_resp);
        end
    endtask

    task automatic test_miss_next();
        fetch(32'h6000_0020);
        tick();
        bus.ufp_rmask = 4'h0;
        checks++;
        if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h6000_0020 || bus.ufp_resp !== 1'b0) begin
            errors++;
            $display("FAIL miss_next_req: got mem_read=%b addr=%h resp=%b want 1 60000020 0", bus.mem_read, bus.mem_addr, bus.ufp_resp);
        end
        tick();
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = mk_line(32'h0000_0100);
        tick();
        bus.mem_resp  = 1'b0;
        checks++;
        if (bus.ufp_resp !== 1'b1 || bus.ufp_rdata !== 32'h0000_0100) begin
            errors++;
            $display("FAIL miss_next_resp: got resp=%b rdata=%h want 1 00000100", bus.ufp_resp, bus.ufp_rdata);
        end
        // old line must be gone
        fetch(32'h6000_0000);
        tick();
        bus.ufp_rmask = 4'h0;
        checks++;
        if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h6000_0000 || bus.ufp_resp !== 1'b0) begin
            errors++;
            $display("FAIL miss_old_line: got mem_read=%b addr=%h resp=%b want 1 60000000 0", bus.mem_read, bus.mem_addr, bus.ufp_resp);
        end
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = mk_line(32'h0000_0012);
        tick();
        bus.mem_resp  = 1'b0;
        checks++;
        if (bus.ufp_resp !== 1'b1 || bus.ufp_rdata !== 32'h0000_0012) begin
            errors++;
            $display("FAIL miss_old_resp: got resp=%b rdata=%h want 1 00000012", bus.ufp_resp, bus.ufp_rdata);
        end
    endtask

    task automatic test_flush_fill();
        fetch(32'h6000_0040);
        tick();
        bus.ufp_rmask = 4'h0;
        tick();
        tick();
        bus.flush = 1'b1;
        tick();
        bus.flush = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h6000_0040 || bus.ufp_resp !== 1'b0 || bus.ufp_ready !== 1'b0) begin
                errors++;
                $display("FAIL flush_hold%0d: got mem_read=%b addr=%h resp=%b ready=%b want 1 60000040 0 0", i, bus.mem_read, bus.mem_addr, bus.ufp_resp, bus.ufp_ready);
            end
            if (i == 0) tick();
        end
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = mk_line(32'h0000_0200);
        tick();
        bus.mem_resp  = 1'b0;
        checks++;
        if (bus.ufp_resp !== 1'b0 || bus.mem_read !== 1'b0 || bus.ufp_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_done: got resp=%b mem_read=%b ready=%b want 0 0 1", bus.ufp_resp, bus.mem_read, bus.ufp_ready);
        end
        fetch(32'h6000_004C);
        tick();
        bus.ufp_rmask = 4'h0;
        checks++;
        if (bus.ufp_resp !== 1'b1 || bus.ufp_rdata !== 32'h0000_0203 || bus.mem_read !== 1'b0) begin
            errors++;
            $display("FAIL flush_then_hit: got resp=%b rdata=%h mem_read=%b want 1 00000203 0", bus.ufp_resp, bus.ufp_rdata, bus.mem_read);
        end
    endtask

    task automatic test_flush_coincident();
        // flush with a would-be hit accept
        fetch(32'h6000_0040);
        bus.flush = 1'b1;
        tick();
        bus.flush     = 1'b0;
        bus.ufp_rmask = 4'h0;
        checks++;
        if (bus.ufp_resp !== 1'b0 || bus.mem_read !== 1'b0) begin
            errors++;
            $display("FAIL flush_hit: got resp=%b mem_read=%b want 0 0", bus.ufp_resp, bus.mem_read);
        end
        // flush together with mem_resp
        fetch(32'h6000_0060);
        tick();
        bus.ufp_rmask = 4'h0;
        tick();
        bus.flush     = 1'b1;
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = mk_line(32'h0000_0300);
        tick();
        bus.flush     = 1'b0;
        bus.mem_resp  = 1'b0;
        checks++;
        if (bus.ufp_resp !== 1'b0 || bus.mem_read !== 1'b0 || bus.ufp_ready !== 1'b1) begin
            errors++;
            $display("FAIL flush_memresp: got resp=%b mem_read=%b ready=%b want 0 0 1", bus.ufp_resp, bus.mem_read, bus.ufp_ready);
        end
        fetch(32'h6000_0064);
        tick();
        bus.ufp_rmask = 4'h0;
        checks++;
        if (bus.ufp_resp !== 1'b1 || bus.ufp_rdata !== 32'h0000_0301) begin
            errors++;
            $display("FAIL flush_memresp_fill: got resp=%b rdata=%h want 1 00000301", bus.ufp_resp, bus.ufp_rdata);
        end
        // stray mem_resp while idle must not touch the line
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = mk_line(32'h0000_0900);
        tick();
        bus.mem_resp  = 1'b0;
        checks++;
        if (bus.ufp_resp !== 1'b0 || bus.mem_read !== 1'b0 || bus.ufp_ready !== 1'b1) begin
            errors++;
            $display("FAIL idle_memresp: got resp=%b mem_read=%b ready=%b want 0 0 1", bus.ufp_resp, bus.mem_read, bus.ufp_ready);
        end
        fetch(32'h6000_0068);
        tick();
        bus.ufp_rmask = 4'h0;
        checks++;
        if (bus.ufp_resp !== 1'b1 || bus.ufp_rdata !== 32'h0000_0302) begin
            errors++;
            $display("FAIL idle_memresp_line: got resp=%b rdata=%h want 1 00000302", bus.ufp_resp, bus.ufp_rdata);
        end
    endtask

    task automatic test_async_reset();
        fetch(32'h6000_0080);
        tick();
        bus.ufp_rmask = 4'h0;
        checks++;
        if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h6000_0080) begin
            errors++;
            $display("FAIL areset_pre: got mem_read=%b addr=%h want 1 60000080", bus.mem_read, bus.mem_addr);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (bus.mem_read !== 1'b0 || bus.ufp_resp !== 1'b0 || bus.ufp_ready !== 1'b0 || bus.mem_addr !== 32'h0) begin
            errors++;
            $display("FAIL areset_async: got mem_read=%b resp=%b ready=%b addr=%h want 0 0 0 0", bus.mem_read, bus.ufp_resp, bus.ufp_ready, bus.mem_addr);
        end
        tick();
        rst = 1'b0;
        // previously resident line must now miss
        fetch(32'h6000_0060);
        tick();
        bus.ufp_rmask = 4'h0;
        checks++;
        if (bus.mem_read !== 1'b1 || bus.mem_addr !== 32'h6000_0060 || bus.ufp_resp !== 1'b0) begin
            errors++;
            $display("FAIL areset_miss: got mem_read=%b addr=%h resp=%b want 1 60000060 0", bus.mem_read, bus.mem_addr, bus.ufp_resp);
        end
        bus.mem_resp  = 1'b1;
        bus.mem_rdata = mk_line(32'h0000_0400);
        tick();
        bus.mem_resp  = 1'b0;
        checks++;
        if (bus.ufp_resp !== 1'b1 || bus.ufp_rdata !== 32'h0000_0400) begin
            errors++;
            $display("FAIL areset_refill: got resp=%b rdata=%h want 1 00000400", bus.ufp_resp, bus.ufp_rdata);
        end
    endtask

    initial begin
        bus.ufp_addr  = 32'h0;
        bus.ufp_rmask = 4'h0;
        bus.flush     = 1'b0;
        bus.mem_resp  = 1'b0;
        bus.mem_rdata = '0;
        test_reset();
        test_cold_fetch();
        test_hit_stream();
        test_miss_next();
        test_flush_fill();
        test_flush_coincident();
        test_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at %0t", $time);
        $fatal(1, "timeout");
    end
endmodule
